// File: rtl/rv_pkg.sv
// Shared RV core definitions used by the load/store unit.
//   - RV opcode constants for loads and stores
//   - funct3 size/sign codes for loads and stores
//   - lsu_err_e   : response error code reported on rsp_err
//   - lsu_state_e : load/store unit sequencing states
package rv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        LSU_OK       = 2'd0,
        LSU_MISALIGN = 2'd1,
        LSU_BUS_TO   = 2'd2,
        LSU_ILLEGAL  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   f3        in   3      funct3 size/sign code
//   we        in   1      1 = store (f3[2] set on a store is illegal)
//   lane      in   LW     byte offset of the access within the bus word
//   wdata     in   XLEN   unshifted store data
//   rdata     in   XLEN   full bus word returned by memory
//   be        out  XLEN/8 byte strobes for the access
//   wdata_sh  out  XLEN   store data moved onto its byte lanes
//   ldata     out  XLEN   load data moved down and sign/zero extended
//   misalign  out  1      lane not a multiple of the access size
//   illegal   out  1      f3 not a valid load/store code for this XLEN
module lsu_lane_align
    import rv_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int BW   = XLEN / 8,
    localparam int LW   = $clog2(XLEN / 8),
    localparam int MW   = $clog2(XLEN)
) (
    input  logic [2:0]      f3,
    input  logic            we,
    input  logic [LW-1:0]   lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [BW-1:0]   be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] ldata,
    output logic            misalign,
    output logic            illegal
);

    logic [1:0]      size;
    logic [LW+2:0]   bit_sh;
    logic [BW-1:0]   bmask;
    logic [XLEN-1:0] raw;
    logic [MW-1:0]   msb;
    logic            fill;

    assign size   = f3[1:0];
    assign bit_sh = {lane, 3'b000};

    always_comb begin
        bmask = '0;
        for (int i = 0; i < BW; i++) begin
            bmask[i] = (i < (1 << size));
        end
        be       = bmask << lane;
        wdata_sh = wdata << bit_sh;

        // 64-bit codes only exist on RV64; 3'b111 never exists.
        illegal  = (f3 == 3'b111) || (we && f3[2]) ||
                   ((XLEN == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
        misalign = (lane & LW'((1 << size) - 1)) != '0;

        raw = rdata >> bit_sh;
        case (size)
            2'd0:    msb = MW'(7);
            2'd1:    msb = MW'(15);
            2'd2:    msb = MW'(31);
            default: msb = MW'(XLEN - 1);
        endcase
        fill  = ~f3[2] & raw[msb];
        ldata = raw;
        for (int i = 0; i < XLEN; i++) begin
            if (i > int'(msb)) begin
                ldata[i] = fill;
            end
        end
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: one request at a time from execute, valid/ready memory
// request, variable-latency response, byte-strobed stores, lane-aligned loads,
// misaligned / illegal-size / bus-timeout error reporting.
//
//   state | meaning
//   IDLE  | ready for a request; errors detected here skip memory
//   ISSUE | mem_valid held with stable addr/be/wdata until mem_ready
//   WAIT  | request accepted, waiting for mem_rvalid or timeout
//   RESP  | one-cycle rsp_valid pulse
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake from execute
//   req_we/f3/base/off/wdata/rd store flag, size code, rs1, imm, rs2, rd
//   rsp_valid/rd/data/err/addr  completion pulse with result and trap address
//   mem_valid/ready             memory request handshake
//   mem_we/addr/be/wdata        lane-aligned memory request
//   mem_rvalid/rdata            read data / write acknowledge
module rv_lsu
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [XLEN-1:0]   req_base,
    input  logic [XLEN-1:0]   req_off,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic [1:0]        rsp_err,
    output logic [XLEN-1:0]   rsp_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int BW = XLEN / 8;
    localparam int LW = $clog2(XLEN / 8);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e      state, state_d;
    logic [XLEN-1:0] ea, ea_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            we_q;
    logic [BW-1:0]   be_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    lsu_err_e        err_q, acc_err;
    logic [CW-1:0]   cnt_q;
    logic            timeout_hit;

    logic [2:0]      al_f3;
    logic            al_we;
    logic [LW-1:0]   al_lane;
    logic [BW-1:0]   al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ldata;
    logic            al_misalign;
    logic            al_illegal;

    assign ea = req_base + req_off;

    // One aligner serves both phases: in IDLE it checks and shifts the incoming
    // request; afterwards it extends returning load data using the held request.
    assign al_f3   = (state == IDLE) ? req_f3 : f3_q;
    assign al_we   = (state == IDLE) ? req_we : we_q;
    assign al_lane = (state == IDLE) ? ea[LW-1:0] : ea_q[LW-1:0];

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .f3       (al_f3),
        .we       (al_we),
        .lane     (al_lane),
        .wdata    (req_wdata),
        .rdata    (mem_rdata),
        .be       (al_be),
        .wdata_sh (al_wdata),
        .ldata    (al_ldata),
        .misalign (al_misalign),
        .illegal  (al_illegal)
    );

    always_comb begin
        acc_err = LSU_OK;
        if (al_illegal) begin
            acc_err = LSU_ILLEGAL;
        end else if (al_misalign) begin
            acc_err = LSU_MISALIGN;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (acc_err != LSU_OK) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_d = mem_rvalid ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_q    <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= LSU_OK;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ea_q    <= ea;
                        f3_q    <= req_f3;
                        rd_q    <= req_rd;
                        we_q    <= req_we;
                        be_q    <= al_be;
                        wdata_q <= al_wdata;
                        rdata_q <= '0;
                        err_q   <= acc_err;
                        cnt_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_ready && mem_rvalid) begin
                        rdata_q <= al_ldata;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mem_rvalid) begin
                        rdata_q <= al_ldata;
                    end else if (timeout_hit) begin
                        err_q <= LSU_BUS_TO;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory and response buses read as zero outside the states that own them.
    assign mem_we    = (state == ISSUE) && we_q;
    assign mem_addr  = (state == ISSUE) ? {ea_q[XLEN-1:LW], {LW{1'b0}}} : '0;
    assign mem_be    = (state == ISSUE) ? be_q : '0;
    assign mem_wdata = (state == ISSUE) ? wdata_q : '0;

    logic load_ok;
    assign load_ok = (state == RESP) && !we_q && (err_q == LSU_OK);

    assign rsp_rd   = load_ok ? rd_q : '0;
    assign rsp_data = load_ok ? rdata_q : '0;
    assign rsp_err  = (state == RESP) ? 2'(err_q) : 2'd0;
    assign rsp_addr = (state == RESP) ? ea_q : '0;

endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // XLEN=32, TIMEOUT=4 instance
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_f3;
    logic [31:0] a_req_base, a_req_off, a_req_wdata;
    logic [4:0]  a_req_rd;
    logic        a_rsp_valid;
    logic [4:0]  a_rsp_rd;
    logic [31:0] a_rsp_data;
    logic [1:0]  a_rsp_err;
    logic [31:0] a_rsp_addr;
    logic        a_mem_valid, a_mem_ready, a_mem_we;
    logic [31:0] a_mem_addr;
    logic [3:0]  a_mem_be;
    logic [31:0] a_mem_wdata;
    logic        a_mem_rvalid;
    logic [31:0] a_mem_rdata;

    // XLEN=64, TIMEOUT=16 instance
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_f3;
    logic [63:0] b_req_base, b_req_off, b_req_wdata;
    logic [4:0]  b_req_rd;
    logic        b_rsp_valid;
    logic [4:0]  b_rsp_rd;
    logic [63:0] b_rsp_data;
    logic [1:0]  b_rsp_err;
    logic [63:0] b_rsp_addr;
    logic        b_mem_valid, b_mem_ready, b_mem_we;
    logic [63:0] b_mem_addr;
    logic [7:0]  b_mem_be;
    logic [63:0] b_mem_wdata;
    logic        b_mem_rvalid;
    logic [63:0] b_mem_rdata;

    rv_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_f3(a_req_f3), .req_base(a_req_base), .req_off(a_req_off),
        .req_wdata(a_req_wdata), .req_rd(a_req_rd),
        .rsp_valid(a_rsp_valid), .rsp_rd(a_rsp_rd), .rsp_data(a_rsp_data),
        .rsp_err(a_rsp_err), .rsp_addr(a_rsp_addr),
        .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
        .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata)
    );

    rv_lsu #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_f3(b_req_f3), .req_base(b_req_base), .req_off(b_req_off),
        .req_wdata(b_req_wdata), .req_rd(b_req_rd),
        .rsp_valid(b_rsp_valid), .rsp_rd(b_rsp_rd), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .rsp_addr(b_rsp_addr),
        .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
        .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata)
    );

    // Presents one request; returns #1 after the accepting edge.
    task automatic drive_a(input logic we, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd);
        a_req_we = we; a_req_f3 = f3; a_req_base = base; a_req_off = off;
        a_req_wdata = wdata; a_req_rd = rd; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic drive_b(input logic we, input logic [2:0] f3, input logic [63:0] base,
                           input logic [63:0] off, input logic [63:0] wdata, input logic [4:0] rd);
        b_req_we = we; b_req_f3 = f3; b_req_base = base; b_req_off = off;
        b_req_wdata = wdata; b_req_rd = rd; b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        a_req_valid = 0; a_req_we = 0; a_req_f3 = 0; a_req_base = 0; a_req_off = 0;
        a_req_wdata = 0; a_req_rd = 0; a_mem_ready = 0; a_mem_rvalid = 0; a_mem_rdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_f3 = 0; b_req_base = 0; b_req_off = 0;
        b_req_wdata = 0; b_req_rd = 0; b_mem_ready = 0; b_mem_rvalid = 0; b_mem_rdata = 0;
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({a_req_ready, a_mem_valid, a_rsp_valid, a_mem_we} !== 4'b1000) begin
            errors++; $display("FAIL reset_a32 ctl got %b want 1000", {a_req_ready, a_mem_valid, a_rsp_valid, a_mem_we});
        end
        checks++;
        if ({a_mem_addr, a_mem_be, a_mem_wdata, a_rsp_data, a_rsp_addr, a_rsp_err, a_rsp_rd} !== '0) begin
            errors++; $display("FAIL reset_a32 buses got addr=%h be=%h err=%h want all 0", a_mem_addr, a_mem_be, a_rsp_err);
        end
        checks++;
        if ({b_req_ready, b_mem_valid, b_rsp_valid, b_mem_be} !== {3'b100, 8'h00}) begin
            errors++; $display("FAIL reset_b64 got ready=%b mv=%b rv=%b be=%h want 1 0 0 00", b_req_ready, b_mem_valid, b_rsp_valid, b_mem_be);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_word;
        a_mem_ready = 1; a_mem_rvalid = 1; a_mem_rdata = 32'h0;
        drive_a(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd3);
        checks++;
        if ({a_mem_valid, a_mem_we, a_mem_addr, a_mem_be, a_mem_wdata, a_rsp_valid, a_req_ready} !==
            {2'b11, 32'h104, 4'hF, 32'hDEADBEEF, 2'b00}) begin
            errors++; $display("FAIL sw_issue got mv=%b addr=%h be=%h wd=%h want 1 104 f deadbeef", a_mem_valid, a_mem_addr, a_mem_be, a_mem_wdata);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_rd, a_rsp_data, a_mem_valid} !==
            {1'b1, 2'd0, 32'h104, 5'd0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL sw_resp got rv=%b err=%0d addr=%h rd=%0d data=%h want 1 0 104 0 0", a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_rd, a_rsp_data);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_req_ready} !== 2'b01) begin
            errors++; $display("FAIL sw_after got rv=%b ready=%b want 0 1", a_rsp_valid, a_req_ready);
        end
    endtask

    task automatic test_byte_lanes;
        a_mem_ready = 1; a_mem_rvalid = 1;
        drive_a(1'b1, 3'b000, 32'h100, 32'h3, 32'h000000A5, 5'd1);
        checks++;
        if ({a_mem_addr, a_mem_be, a_mem_wdata} !== {32'h100, 4'b1000, 32'hA5000000}) begin
            errors++; $display("FAIL sb_lane got addr=%h be=%b wd=%h want 100 1000 a5000000", a_mem_addr, a_mem_be, a_mem_wdata);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_rd} !== {1'b1, 2'd0, 5'd0}) begin
            errors++; $display("FAIL sb_resp got rv=%b err=%0d rd=%0d want 1 0 0", a_rsp_valid, a_rsp_err, a_rsp_rd);
        end
        step();

        a_mem_rdata = 32'h80123456;
        drive_a(1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd5);
        checks++;
        if ({a_mem_valid, a_mem_we, a_mem_be} !== {2'b10, 4'b1000}) begin
            errors++; $display("FAIL lb_issue got mv=%b we=%b be=%b want 1 0 1000", a_mem_valid, a_mem_we, a_mem_be);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_rd, a_rsp_data} !== {1'b1, 2'd0, 5'd5, 32'hFFFFFF80}) begin
            errors++; $display("FAIL lb_sext got rv=%b rd=%0d data=%h want 1 5 ffffff80", a_rsp_valid, a_rsp_rd, a_rsp_data);
        end
        step();

        drive_a(1'b0, 3'b100, 32'h100, 32'h3, 32'h0, 5'd6);
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_data} !== {1'b1, 5'd6, 32'h00000080}) begin
            errors++; $display("FAIL lbu_zext got rv=%b rd=%0d data=%h want 1 6 00000080", a_rsp_valid, a_rsp_rd, a_rsp_data);
        end
        step();

        a_mem_rdata = 32'h8001ABCD;
        drive_a(1'b0, 3'b001, 32'h100, 32'h2, 32'h0, 5'd8);
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_data} !== {1'b1, 5'd8, 32'hFFFF8001}) begin
            errors++; $display("FAIL lh_upper got rv=%b rd=%0d data=%h want 1 8 ffff8001", a_rsp_valid, a_rsp_rd, a_rsp_data);
        end
        step();
    endtask

    task automatic test_errors;
        logic        we_v [5];
        logic [2:0]  f3_v [5];
        logic [31:0] off_v[5];
        logic [1:0]  err_v[5];
        we_v  = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
        f3_v  = '{3'b001, 3'b011, 3'b011, 3'b100, 3'b010};
        off_v = '{32'h1,  32'h0,  32'h1,  32'h0,  32'h2};
        err_v = '{2'd1,   2'd3,   2'd3,   2'd3,   2'd1};
        a_mem_ready = 1; a_mem_rvalid = 1; a_mem_rdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            drive_a(we_v[i], f3_v[i], 32'h100, off_v[i], 32'hFFFFFFFF, 5'd9);
            checks++;
            if ({a_mem_valid, a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_data, a_rsp_rd} !==
                {1'b0, 1'b1, err_v[i], 32'h100 + off_v[i], 32'h0, 5'd0}) begin
                errors++; $display("FAIL err_case%0d got mv=%b rv=%b err=%0d addr=%h data=%h rd=%0d want 0 1 %0d %h 0 0",
                                   i, a_mem_valid, a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_data, a_rsp_rd, err_v[i], 32'h100 + off_v[i]);
            end
            step();
            checks++;
            if ({a_req_ready, a_rsp_valid, a_mem_valid} !== 3'b100) begin
                errors++; $display("FAIL err_case%0d_after got ready=%b rv=%b mv=%b want 1 0 0", i, a_req_ready, a_rsp_valid, a_mem_valid);
            end
        end
    endtask

    task automatic test_timeout;
        a_mem_ready = 1; a_mem_rvalid = 0;
        drive_a(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd4);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({a_rsp_valid, a_mem_valid, a_req_ready} !== 3'b000) begin
                errors++; $display("FAIL to_wait%0d got rv=%b mv=%b ready=%b want 0 0 0", i, a_rsp_valid, a_mem_valid, a_req_ready);
            end
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_data, a_rsp_rd, a_rsp_addr} !== {1'b1, 2'd2, 32'h0, 5'd0, 32'h200}) begin
            errors++; $display("FAIL to_resp got rv=%b err=%0d data=%h rd=%0d addr=%h want 1 2 0 0 200", a_rsp_valid, a_rsp_err, a_rsp_data, a_rsp_rd, a_rsp_addr);
        end
        step();
        a_mem_rvalid = 1; a_mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({a_rsp_valid, a_req_ready, a_mem_valid} !== 3'b010) begin
                errors++; $display("FAIL to_late_beat%0d got rv=%b ready=%b mv=%b want 0 1 0", i, a_rsp_valid, a_req_ready, a_mem_valid);
            end
        end
        a_mem_rdata = 32'h12345678;
        drive_a(1'b0, 3'b010, 32'h200, 32'h4, 32'h0, 5'd7);
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_rd, a_rsp_data} !== {1'b1, 2'd0, 5'd7, 32'h12345678}) begin
            errors++; $display("FAIL to_next got rv=%b err=%0d rd=%0d data=%h want 1 0 7 12345678", a_rsp_valid, a_rsp_err, a_rsp_rd, a_rsp_data);
        end
        step();
    endtask

    task automatic test_stall;
        a_mem_ready = 0; a_mem_rvalid = 0;
        drive_a(1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h11223344, 5'd0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({a_mem_valid, a_mem_we, a_mem_addr, a_mem_be, a_mem_wdata, a_req_ready, a_rsp_valid} !==
                {2'b11, 32'h4, 4'hF, 32'h11223344, 2'b00}) begin
                errors++; $display("FAIL stall%0d got mv=%b addr=%h be=%h wd=%h ready=%b want 1 4 f 11223344 0",
                                   i, a_mem_valid, a_mem_addr, a_mem_be, a_mem_wdata, a_req_ready);
            end
            if (i < 4) step();
        end
        a_mem_ready = 1;
        step();
        checks++;
        if ({a_mem_valid, a_rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL stall_wait got mv=%b rv=%b want 0 0", a_mem_valid, a_rsp_valid);
        end
        a_mem_rvalid = 1;
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_addr} !== {1'b1, 2'd0, 32'h4}) begin
            errors++; $display("FAIL stall_resp got rv=%b err=%0d addr=%h want 1 0 4", a_rsp_valid, a_rsp_err, a_rsp_addr);
        end
        step();
        a_mem_rvalid = 0; a_mem_rdata = 32'hBEEF0000;
        drive_a(1'b0, 3'b101, 32'h100, 32'h6, 32'h0, 5'd2);
        step();
        a_mem_rvalid = 1;
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_rsp_rd, a_rsp_data} !== {1'b1, 2'd0, 5'd2, 32'h0000BEEF}) begin
            errors++; $display("FAIL lhu_wait got rv=%b err=%0d rd=%0d data=%h want 1 0 2 0000beef", a_rsp_valid, a_rsp_err, a_rsp_rd, a_rsp_data);
        end
        step();
        a_mem_rvalid = 0;
    endtask

    task automatic test_xlen64;
        b_mem_ready = 1; b_mem_rvalid = 1; b_mem_rdata = 64'hF000000000000000;
        drive_b(1'b0, 3'b110, 64'h1000, 64'h4, 64'h0, 5'd3);
        checks++;
        if ({b_mem_valid, b_mem_addr, b_mem_be} !== {1'b1, 64'h1000, 8'hF0}) begin
            errors++; $display("FAIL lwu64_issue got mv=%b addr=%h be=%h want 1 1000 f0", b_mem_valid, b_mem_addr, b_mem_be);
        end
        step();
        checks++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data} !== {1'b1, 2'd0, 5'd3, 64'h00000000F0000000}) begin
            errors++; $display("FAIL lwu64 got rv=%b err=%0d rd=%0d data=%h want 1 0 3 00000000f0000000", b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data);
        end
        step();
        drive_b(1'b0, 3'b010, 64'h1000, 64'h4, 64'h0, 5'd3);
        step();
        checks++;
        if ({b_rsp_valid, b_rsp_data} !== {1'b1, 64'hFFFFFFFFF0000000}) begin
            errors++; $display("FAIL lw64_sext got rv=%b data=%h want 1 fffffffff0000000", b_rsp_valid, b_rsp_data);
        end
        step();
        b_mem_rdata = 64'h8000000000000001;
        drive_b(1'b0, 3'b011, 64'h1000, 64'h8, 64'h0, 5'd11);
        step();
        checks++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data} !== {1'b1, 2'd0, 5'd11, 64'h8000000000000001}) begin
            errors++; $display("FAIL ld64 got rv=%b err=%0d rd=%0d data=%h want 1 0 11 8000000000000001", b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data);
        end
        step();
        drive_b(1'b1, 3'b000, 64'h1000, 64'h5, 64'hAB, 5'd0);
        checks++;
        if ({b_mem_we, b_mem_addr, b_mem_be, b_mem_wdata} !== {1'b1, 64'h1000, 8'h20, 64'h0000AB0000000000}) begin
            errors++; $display("FAIL sb64_lane got we=%b addr=%h be=%h wd=%h want 1 1000 20 0000ab0000000000", b_mem_we, b_mem_addr, b_mem_be, b_mem_wdata);
        end
        step(); step();
        drive_b(1'b1, 3'b011, 64'h1000, 64'h4, 64'h0, 5'd0);
        checks++;
        if ({b_mem_valid, b_rsp_valid, b_rsp_err} !== {2'b01, 2'd1}) begin
            errors++; $display("FAIL sd64_misalign got mv=%b rv=%b err=%0d want 0 1 1", b_mem_valid, b_rsp_valid, b_rsp_err);
        end
        step();
    endtask

    task automatic test_reset_mid;
        b_mem_ready = 0; b_mem_rvalid = 0;
        drive_b(1'b0, 3'b011, 64'h1000, 64'h8, 64'h0, 5'd4);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b_mem_valid, b_req_ready, b_rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL rst_issue got mv=%b ready=%b rv=%b want 0 1 0", b_mem_valid, b_req_ready, b_rsp_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        b_mem_ready = 1;
        drive_b(1'b0, 3'b011, 64'h1000, 64'h8, 64'h0, 5'd4);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b_mem_valid, b_req_ready, b_rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL rst_wait got mv=%b ready=%b rv=%b want 0 1 0", b_mem_valid, b_req_ready, b_rsp_valid);
        end
        step();
        rst_n = 1'b1;
        b_mem_rvalid = 1; b_mem_rdata = 64'h0123456789ABCDEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({b_rsp_valid, b_req_ready, b_mem_valid} !== 3'b010) begin
                errors++; $display("FAIL rst_quiet%0d got rv=%b ready=%b mv=%b want 0 1 0", i, b_rsp_valid, b_req_ready, b_mem_valid);
            end
        end
        drive_b(1'b0, 3'b011, 64'h2000, 64'h0, 64'h0, 5'd12);
        step();
        checks++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data} !== {1'b1, 2'd0, 5'd12, 64'h0123456789ABCDEF}) begin
            errors++; $display("FAIL rst_recover got rv=%b err=%0d rd=%0d data=%h want 1 0 12 0123456789abcdef", b_rsp_valid, b_rsp_err, b_rsp_rd, b_rsp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_lanes();
        test_errors();
        test_timeout();
        test_stall();
        test_xlen64();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
